md_unit: RTL
============

// Module: md_unit
// PURPOSE
// - Multiply/divide unit of the E stage: executes mult/multu/div/divu and mthi/mtlo,
//   owns the HI/LO registers and presents them to the mfhi/mflo result mux.
// - Driven by the E-stage decode of the funct field, which identifies the op and
//   asserts the start/write strobes. Its busy/start outputs feed the D-stage stall logic.
// PARAMETERS
// - MULT_CYCLES  5   busy cycles for mult/multu (must be >= 1)
// - DIV_CYCLES   10  busy cycles for div/divu (must be >= 1)
// PORTS
// - clk       in   1   clock; all state updates on the rising edge
// - reset     in   1   synchronous, active-high reset
// - md_start  in   1   one-cycle strobe to launch md_op with md_a/md_b
// - md_op     in   2   0=mult 1=multu 2=div 3=divu (sampled only with md_start)
// - md_a      in   32  rs operand (dividend / multiplicand / mthi-mtlo data)
// - md_b      in   32  rt operand (divisor / multiplier)
// - hilo_we   in   2   bit1=mthi (HI<=md_a), bit0=mtlo (LO<=md_a)
// - hi        out  32  architectural HI
// - lo        out  32  architectural LO
// - md_busy   out  1   operation in flight
// - md_hold   out  1   md_start | md_busy; used by the D stage to stall md-class instructions
// BEHAVIOUR
// - Reset: hi=0, lo=0, md_busy=0, cycle counter=0, shadow result regs=0.
// - Accept: on an edge with md_start=1 and md_busy=0, do all of the following:
//   - latch the 64-bit result into shadow regs: mult = signed 32x32;
//     multu = unsigned; div/divu: LO=quotient, HI=remainder;
//   - load counter = MULT_CYCLES or DIV_CYCLES;
//   - set md_busy=1.
// - Division sign rules: signed div truncates toward zero; remainder takes the
//   sign of the dividend.
// - Special divide cases:
//   - 0x80000000 / -1 (signed): LO=0x80000000, HI=0.
//   - divisor==0: no HI/LO update at completion; busy timing is unchanged.
// - Run: each edge while busy, counter decrements. On the edge where counter==1,
//   hi/lo <= shadow and md_busy <= 0. md_busy is therefore high for exactly N
//   cycles, and new hi/lo are visible in the first cycle md_busy is low.
// - hi/lo hold their old values throughout busy. The counter is a 5-bit down
//   counter and must never wrap below 0.
// - FSM has two states:
//   - IDLE -> BUSY on accept.
//   - BUSY -> IDLE on counter==1.
//   - reset forces IDLE from any state.
// - md_start while busy: ignored entirely. The upstream stall prevents this; the
//   unit must still be safe if it occurs.
// - hilo_we while idle and md_start=0: write takes effect at the edge; both bits
//   set writes both.
// - hilo_we while busy, or together with md_start: ignored.
// - Reset mid-operation: in-flight result is discarded, hi/lo=0, idle next cycle.
// - Combinational path: md_hold depends only on md_start and the md_busy flop.
//   There is no other input-to-output combinational path.
// CONFIGURATION
// - MD_ABORT_EN defined:
//   - adds input md_abort (1 bit), used by exception/interrupt flush;
//   - while busy, md_abort=1 returns to IDLE next edge with hi/lo unchanged;
//   - md_abort on the same edge as md_start cancels the accept;
//   - md_abort while idle has no effect.
// - MD_ABORT_EN undefined: port absent; an accepted op always completes unless reset.
// TESTING
// - mult a=-3 (0xFFFFFFFD), b=5
//   -> busy exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
// - multu a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5.
// - divu a=0xFFFFFFFF, b=2 -> lo=0x7FFFFFFF, hi=0x00000001 after 10 busy cycles.
// - div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
// - div a=5, b=0 with hi/lo preset via mthi 0x11 / mtlo 0x22
//   -> busy 10 cycles; hi=0x11, lo=0x22 unchanged.
// - Start+busy protection:
//   - md_start during busy: ignored; first result still lands on schedule.
//   - mthi during busy: dropped.
// - Reset mid-operation:
//   - reset at busy cycle 3 of a div -> hi=lo=0, md_busy=0 next cycle.
//   - under MD_ABORT_EN, md_abort at cycle 3 -> idle next cycle, hi/lo keep pre-op values.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit that owns HI/LO and feeds the D-stage stall.
// Optional flush input md_abort is compiled in when MD_ABORT_EN is defined.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [1:0]  md_op,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    input  logic [1:0]  hilo_we,
`ifdef MD_ABORT_EN
    input  logic        md_abort,
`endif
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_busy,
    output logic        md_hold
);

    // Handshake: md_start is accepted only when md_busy is low; md_busy stays high
    // for exactly the op's cycle count and results appear when it drops.
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state;
    logic [4:0]  count;
    logic [31:0] shadow_hi;
    logic [31:0] shadow_lo;
    logic        skip_write;
    logic        abort;

`ifdef MD_ABORT_EN
    assign abort = md_abort;
`else
    assign abort = 1'b0;
`endif

    assign md_hold = md_start | md_busy;

    logic        a_neg, b_neg, is_div, div_zero;
    logic [31:0] a_mag, b_mag, b_safe, uq, ur, mq, mr;
    logic [63:0] prod_s, prod_u;
    logic [31:0] res_hi, res_lo;

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 naturally.
    always_comb begin
        is_div   = md_op[1];
        div_zero = (md_b == 32'd0);
        a_neg    = md_a[31];
        b_neg    = md_b[31];
        a_mag    = a_neg ? (32'd0 - md_a) : md_a;
        b_mag    = b_neg ? (32'd0 - md_b) : md_b;
        b_safe   = div_zero ? 32'd1 : md_b;
        uq       = md_a / b_safe;
        ur       = md_a % b_safe;
        mq       = div_zero ? 32'd0 : a_mag / b_mag;
        mr       = div_zero ? 32'd0 : a_mag % b_mag;
        prod_s   = {{32{md_a[31]}}, md_a} * {{32{md_b[31]}}, md_b};
        prod_u   = {32'd0, md_a} * {32'd0, md_b};
        res_hi   = 32'd0;
        res_lo   = 32'd0;
        case (md_op)
            2'd0: begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            2'd1: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            2'd2: begin
                res_lo = (a_neg ^ b_neg) ? (32'd0 - mq) : mq;
                res_hi = a_neg ? (32'd0 - mr) : mr;
            end
            default: begin res_hi = ur; res_lo = uq; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            md_busy    <= 1'b0;
            count      <= 5'd0;
            shadow_hi  <= 32'd0;
            shadow_lo  <= 32'd0;
            skip_write <= 1'b0;
            hi         <= 32'd0;
            lo         <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_start) begin
                        if (!abort) begin
                            state      <= BUSY;
                            md_busy    <= 1'b1;
                            count      <= is_div ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
                            shadow_hi  <= res_hi;
                            shadow_lo  <= res_lo;
                            skip_write <= is_div & div_zero;
                        end
                    end else begin
                        if (hilo_we[1]) hi <= md_a;
                        if (hilo_we[0]) lo <= md_a;
                    end
                end
                default: begin
                    if (abort) begin
                        state   <= IDLE;
                        md_busy <= 1'b0;
                        count   <= 5'd0;
                    end else if (count <= 5'd1) begin
                        // <=1 rather than ==1 so the counter can never wrap.
                        state   <= IDLE;
                        md_busy <= 1'b0;
                        count   <= 5'd0;
                        if (!skip_write) begin
                            hi <= shadow_hi;
                            lo <= shadow_lo;
                        end
                    end else begin
                        count <= count - 5'd1;
                    end
                end
            endcase
        end
    end

endmodule
